// File: rtl/layer_in_buf.sv
// Double-buffered frame assembler: collects IN activations per frame into one
// bank while the other bank is presented in parallel to the fc layer.
module layer_in_buf #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IN    = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_x [0:IN-1],
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic [15:0]      frame_cnt
);

  localparam int unsigned IW       = (IN > 1) ? $clog2(IN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(IN - 1);
  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] DROP = 1'b1;

  logic [0:0]       state, state_n;
  logic [IW-1:0]    idx, idx_n;
  logic             wb, wb_n;
  logic             rb, rb_n;
  logic [1:0]       full, full_n;
  logic             err_q, err_n;
  logic [15:0]      cnt_q, cnt_n;
  logic             accept;
  logic             rel;
  logic             wr_en;

  logic [WIDTH-1:0] bank0 [0:IN-1];
  logic [WIDTH-1:0] bank1 [0:IN-1];

  assign in_ready  = (state == DROP) | ~full[wb];
  assign accept    = in_valid & in_ready;
  assign rel       = full[rb] & out_ready;
  assign out_valid = full[rb];
  assign frame_err = err_q;
  assign frame_cnt = cnt_q;

  // Next-state: release of the read bank and commit of the write bank are independent
  always_comb begin
    state_n = state;
    idx_n   = idx;
    wb_n    = wb;
    rb_n    = rb;
    full_n  = full;
    err_n   = 1'b0;
    cnt_n   = cnt_q;
    wr_en   = 1'b0;

    if (rel) begin
      full_n[rb] = 1'b0;
      rb_n       = ~rb;
    end

    if (accept) begin
      case (state)
        FILL: begin
          wr_en = 1'b1;
          if (idx == LAST_IDX) begin
            idx_n = '0;
            if (in_last) begin
              full_n[wb] = 1'b1;
              wb_n       = ~wb;
              if (cnt_q != 16'hFFFF) cnt_n = cnt_q + 16'd1;
            end else begin
              err_n   = 1'b1;
              state_n = DROP;
            end
          end else if (in_last) begin
            idx_n = '0;
            err_n = 1'b1;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
        DROP: begin
          if (in_last) state_n = FILL;
        end
        default: state_n = FILL;
      endcase
    end
  end

  // Control state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      idx   <= '0;
      wb    <= 1'b0;
      rb    <= 1'b0;
      full  <= 2'b00;
      err_q <= 1'b0;
      cnt_q <= 16'd0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      wb    <= wb_n;
      rb    <= rb_n;
      full  <= full_n;
      err_q <= err_n;
      cnt_q <= cnt_n;
    end
  end

  // Data banks carry no reset; contents only matter once a bank is marked full
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wb) bank1[idx] <= in_data;
      else    bank0[idx] <= in_data;
    end
  end

  always_comb begin
    for (int k = 0; k < int'(IN); k++) begin
      out_x[k] = rb ? bank1[k] : bank0[k];
    end
  end

endmodule

// File: tb/tb_layer_in_buf.sv
// Bench for layer_in_buf: table of frame shapes plus hand-written sequences,
// with delivered frames checked against a queue of expected frames.
module tb_layer_in_buf;

  localparam int unsigned W = 8;
  localparam int unsigned N = 128;

  typedef logic [N-1:0][W-1:0] frame_t;

  typedef struct {
    int nbeats;
    int lastpos;
    int pat;
    int err_beat;
    int exp_err;
    int exp_inc;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [W-1:0] out_x [0:N-1];
  logic         out_valid;
  logic         out_ready;
  logic         frame_err;
  logic [15:0]  frame_cnt;

  int     n_cmp = 0;
  int     n_bad = 0;
  int     err_seen = 0;
  int     exp_cnt = 0;
  frame_t sb_q [$];
  frame_t mon_exp;
  int     mon_bad;
  int     mon_first;

  layer_in_buf #(.WIDTH(W), .IN(N)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_x(out_x), .out_valid(out_valid), .out_ready(out_ready),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every consumed frame is compared against the oldest expected frame
  always @(negedge clk) begin
    if (frame_err === 1'b1) err_seen++;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_frame: out_valid=1 with no frame expected");
      end else begin
        mon_exp   = sb_q.pop_front();
        mon_bad   = 0;
        mon_first = -1;
        for (int k = 0; k < int'(N); k++) begin
          if (out_x[k] !== mon_exp[k]) begin
            mon_bad++;
            if (mon_first < 0) mon_first = k;
          end
        end
        if (mon_bad != 0) begin
          n_bad++;
          $display("FAIL frame_data: %0d words differ, out_x[%0d]=%0h expected %0h",
                   mon_bad, mon_first, out_x[mon_first], mon_exp[mon_first]);
        end
      end
    end
  end

  function automatic frame_t make_frame(input int pat, input int salt);
    frame_t f;
    for (int k = 0; k < int'(N); k++) begin
      case (pat)
        0:       f[k] = W'(k);
        1:       f[k] = W'($urandom);
        2:       f[k] = ~W'(k);
        default: f[k] = W'(k * 3 + salt);
      endcase
    end
    return f;
  endfunction

  task automatic beat(input logic [W-1:0] d, input logic l, output bit ok);
    int t;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    ok = 1'b0;
    t  = 0;
    while (!ok && t < 600) begin
      @(negedge clk);
      if (in_ready === 1'b1) ok = 1'b1;
      t++;
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL beat_timeout: in_ready got 0 expected 1 within 600 cycles");
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input frame_t f, input int nbeats, input int lastpos,
                            input int err_beat, input bit push, input bit ready_on_last);
    bit ok;
    logic [W-1:0] d;
    if (push) sb_q.push_back(f);
    for (int b = 0; b < nbeats; b++) begin
      d = (b < int'(N)) ? f[b] : 8'hEE;
      if (ready_on_last && b == lastpos) out_ready = 1'b1;
      beat(d, (b == lastpos), ok);
      if (b == err_beat) check("err_pulse", 32'(frame_err), 32'd1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb_q.size() != 0 || out_valid === 1'b1) && t < 1000) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain_queue_empty", 32'(sb_q.size()), 32'd0);
  endtask

  vec_t   vecs [5];
  frame_t fa, fb, fc;
  int     err0;

  initial begin
    vecs[0] = '{nbeats: 128, lastpos: 127, pat: 1, err_beat: -1,  exp_err: 0, exp_inc: 1};
    vecs[1] = '{nbeats: 51,  lastpos: 50,  pat: 0, err_beat: 50,  exp_err: 1, exp_inc: 0};
    vecs[2] = '{nbeats: 128, lastpos: 127, pat: 2, err_beat: -1,  exp_err: 0, exp_inc: 1};
    vecs[3] = '{nbeats: 130, lastpos: 129, pat: 1, err_beat: 127, exp_err: 1, exp_inc: 0};
    vecs[4] = '{nbeats: 128, lastpos: 127, pat: 3, err_beat: -1,  exp_err: 0, exp_inc: 1};

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_frame_cnt", 32'(frame_cnt), 32'd0);

    // Single frame with data = index; out_valid for exactly one cycle
    out_ready = 1'b1;
    fa = make_frame(0, 0);
    send_frame(fa, 128, 127, -1, 1'b1, 1'b0);
    exp_cnt++;
    check("single_latency_out_valid", 32'(out_valid), 32'd1);
    check("single_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    @(posedge clk); #1;
    check("single_out_valid_drop", 32'(out_valid), 32'd0);

    foreach (vecs[i]) begin
      err0 = err_seen;
      fa = make_frame(vecs[i].pat, i);
      send_frame(fa, vecs[i].nbeats, vecs[i].lastpos, vecs[i].err_beat,
                 (vecs[i].exp_inc != 0), 1'b0);
      exp_cnt += vecs[i].exp_inc;
      repeat (3) @(posedge clk); #1;
      check($sformatf("vec%0d_err_count", i), 32'(err_seen - err0), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_frame_cnt", i), 32'(frame_cnt), 32'(exp_cnt));
    end
    drain();

    // Backpressure: two frames fill both banks, third waits until release
    out_ready = 1'b0;
    fa = make_frame(3, 1);
    fb = make_frame(3, 2);
    fc = make_frame(3, 3);
    send_frame(fa, 128, 127, -1, 1'b1, 1'b0);
    send_frame(fb, 128, 127, -1, 1'b1, 1'b0);
    exp_cnt += 2;
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_out_valid_held", 32'(out_valid), 32'd1);
    fork
      send_frame(fc, 128, 127, -1, 1'b1, 1'b0);
      begin
        repeat (8) @(posedge clk); #1;
        check("bp_stall_in_ready", 32'(in_ready), 32'd0);
        check("bp_hold_x0", 32'(out_x[0]), 32'(fa[0]));
        out_ready = 1'b1;
      end
    join
    exp_cnt++;
    drain();
    check("bp_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));

    // Commit of the write bank on the same edge the held bank is released
    out_ready = 1'b0;
    fa = make_frame(3, 10);
    fb = make_frame(3, 20);
    send_frame(fa, 128, 127, -1, 1'b1, 1'b0);
    check("sim_hold_valid", 32'(out_valid), 32'd1);
    send_frame(fb, 128, 127, -1, 1'b1, 1'b1);
    exp_cnt += 2;
    check("sim_out_valid", 32'(out_valid), 32'd1);
    check("sim_in_ready", 32'(in_ready), 32'd1);
    check("sim_out_x0", 32'(out_x[0]), 32'(fb[0]));
    check("sim_out_xlast", 32'(out_x[N-1]), 32'(fb[N-1]));
    drain();
    check("sim_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));

    // Reset after beat 60 of a frame
    fa = make_frame(2, 0);
    send_frame(fa, 61, -1, -1, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_frame_err", 32'(frame_err), 32'd0);
    check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    exp_cnt = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    fb = make_frame(1, 0);
    send_frame(fb, 128, 127, -1, 1'b1, 1'b0);
    exp_cnt++;
    drain();
    check("midrst_after_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
